// File: rtl/inv_sub_bytes_pkg.sv
// +-----------------------------------------------------------------------------
// | Module   : inv_sub_bytes_pkg
// | Brief    : Shared FSM state enum, AES width constants and InvShiftRows map.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package inv_sub_bytes_pkg;

    localparam int c_BYTE_W    = 8;
    localparam int c_NUM_BYTES = 16;
    localparam int c_STATE_W   = c_BYTE_W * c_NUM_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Byte index = row + 4*col; sub byte (r, c) lands in output column (c + r) mod 4.
    function automatic logic [3:0] inv_shift_rows_dst(input logic [3:0] src);
        logic [1:0] row;
        logic [1:0] col;
        row = src[1:0];
        col = src[3:2];
        return {col + row, row};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_sub_bytes_inv_sbox.sv
// +-----------------------------------------------------------------------------
// | Module   : inv_sbox
// | Brief    : AES inverse S-box (inverse affine, then GF(2^8) inverse), 1-cycle registered.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module inv_sbox
    import inv_sub_bytes_pkg::*;
(
    input  logic                clk,
    input  logic [c_BYTE_W-1:0] i_byte,
    output logic [c_BYTE_W-1:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_pre;
    logic [7:0] r_byte;

    assign w_pre = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
                 ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;

    always_ff @(posedge clk) begin
        r_byte <= gf_inv(w_pre);
    end

    assign o_byte = r_byte;

endmodule

`default_nettype wire

// File: rtl/inv_sub_bytes.sv
// +-----------------------------------------------------------------------------
// | Module   : inv_sub_bytes
// | Brief    : AES InvSubBytes over LANES bytes/cycle; INV_SUB_BYTES_SHIFT_ROWS_EN
// |            additionally applies InvShiftRows at result write.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module inv_sub_bytes
    import inv_sub_bytes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [c_STATE_W-1:0] in_state,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [c_STATE_W-1:0] out_state
);

    localparam int c_N     = c_NUM_BYTES / LANES;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [c_CNT_W-1:0]  r_grp;
    logic [c_CNT_W-1:0]  r_wr_grp;
    logic                r_wr_en;
    logic [c_BYTE_W-1:0] r_in  [c_NUM_BYTES];
    logic [c_BYTE_W-1:0] r_res [c_NUM_BYTES];
    logic [c_BYTE_W-1:0] w_sbox_in  [LANES];
    logic [c_BYTE_W-1:0] w_sbox_out [LANES];
    logic [3:0]          w_dst [LANES];

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN:   if (r_grp == c_LAST) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The sbox outputs of the group issued last cycle are written this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grp    <= '0;
            r_wr_grp <= '0;
            r_wr_en  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_en  <= (r_state == ST_RUN);
            r_wr_grp <= r_grp;
            if (r_state == ST_RUN) r_grp <= (r_grp == c_LAST) ? '0 : r_grp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < c_NUM_BYTES; j++) r_in[j] <= '0;
        end else if (in_valid && in_ready) begin
            for (int j = 0; j < c_NUM_BYTES; j++) r_in[j] <= in_state[c_STATE_W-1-8*j -: 8];
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_sbox_in[l] = r_in[4'(int'(r_grp) * LANES + l)];
`ifdef INV_SUB_BYTES_SHIFT_ROWS_EN
            w_dst[l] = inv_shift_rows_dst(4'(int'(r_wr_grp) * LANES + l));
`else
            w_dst[l] = 4'(int'(r_wr_grp) * LANES + l);
`endif
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .clk    (clk),
            .i_byte (w_sbox_in[l]),
            .o_byte (w_sbox_out[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < c_NUM_BYTES; j++) r_res[j] <= '0;
        end else if (r_wr_en) begin
            for (int l = 0; l < LANES; l++) r_res[w_dst[l]] <= w_sbox_out[l];
        end
    end

    always_comb begin
        out_state = '0;
        for (int j = 0; j < c_NUM_BYTES; j++) out_state[c_STATE_W-1-8*j -: 8] = r_res[j];
    end

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes.sv
// +-----------------------------------------------------------------------------
// | Module   : tb_inv_sub_bytes
// | Brief    : Self-checking bench for inv_sub_bytes against a table-driven AES model.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_inv_sub_bytes;

    localparam int LANES     = 4;
    localparam int N         = 16 / LANES;
    localparam int ABORT_CYC = (N >= 3) ? 3 : 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    inv_sub_bytes #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [7:0]   sub [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sub[i] = inv_tbl[st[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
`ifdef INV_SUB_BYTES_SHIFT_ROWS_EN
                o[127-8*(r+4*c) -: 8] = sub[r + 4*((c - r + 4) % 4)];
`else
                o[127-8*(r+4*c) -: 8] = sub[r + 4*c];
`endif
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the first cycle out_valid is seen; the caller ends the HOLD.
    task automatic run_txn(input logic [127:0] st, output logic [127:0] res);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            step();
            cyc++;
        end
        chk("accept_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_state = st;
        step();
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            step();
            cyc++;
        end
        chk("latency", 128'(cyc), 128'(N + 2));
        res = out_state;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] held;
        logic [127:0] st;
        logic [7:0]   inv_x;
        int           bad;

        for (int x = 0; x < 256; x++) begin
            inv_x = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul_ref(8'(x), 8'(y)) == 8'h01) inv_x = 8'(y);
            fwd_tbl[x] = affine_fwd(inv_x);
        end
        for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
        step();
        step();
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_state", out_state, 128'h0);
        rst = 1'b0;
        step();
        chk("reset_in_ready", 128'(in_ready), 128'(1));

        // All bytes 0x63 invert to zero in both builds.
        run_txn({16{8'h63}}, res);
        step();
        chk("all_63", res, 128'h0);

        run_txn(128'h000102030405060708090a0b0c0d0e0f, res);
        step();
`ifdef INV_SUB_BYTES_SHIFT_ROWS_EN
        chk("vector_0to15", res, 128'h52f3a3383009d79ebf366afb8140a5d5);
`else
        chk("vector_0to15", res, 128'h52096ad53036a538bf40a39e81f3d7fb);
`endif

        for (int t = 0; t < 20; t++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            run_txn(st, res);
            step();
            chk("random", res, model(st));
        end

        // Backpressure: result must stay frozen and ignore new offers.
        out_ready = 1'b0;
        st = {$urandom, $urandom, $urandom, $urandom};
        run_txn(st, held);
        chk("hold_result", held, model(st));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            chk("hold_stable", out_state, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_hs_valid", 128'(out_valid), 128'(0));
        chk("post_hs_in_ready", 128'(in_ready), 128'(1));
        st = {$urandom, $urandom, $urandom, $urandom};
        run_txn(st, res);
        step();
        chk("after_hold", res, model(st));

        // Abort mid-operation with reset.
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        step();
        in_valid = 1'b0;
        repeat (ABORT_CYC - 1) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        bad = 0;
        for (int i = 0; i < 2 * N + 6; i++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        chk("abort_no_valid", 128'(bad), 128'(0));
        st = {$urandom, $urandom, $urandom, $urandom};
        run_txn(st, res);
        step();
        chk("after_abort", res, model(st));

        // Every byte value, replicated across the whole state.
        for (int v = 0; v < 256; v++) begin
            st = {16{8'(v)}};
            run_txn(st, res);
            step();
            chk("sweep", res, model(st));
            chk("sweep_fwd", 128'(fwd_tbl[res[127:120]]), 128'(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
